// File: rtl/fifo_sym_packer_pkg.sv
// fifo_sym_packer_pkg
//   Shared types and helpers for the symbol packer.
//   state_e : FILL collects symbols into the word register, OUT holds a word
//             on the valid/ready port until it is accepted.
//   cw_f    : width of the symbol-count field, enough to hold 0..PACK.
package fifo_sym_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_e;

  function automatic int cw_f(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/fifo_sym_packer_if.sv
// fifo_sym_packer_if
//   Bundles the FIFO-side pop interface and the word-side valid/ready port.
//   master : the packer (drives pop, valid, data, count)
//   slave  : the environment (FIFO + downstream consumer)
//   din/empty/pop : FIFO dout, empty flag, pop strobe
//   flush         : request to emit a partial word
//   ready/valid   : word handshake; data/count carry the word and its size
interface fifo_sym_packer_if #(
  parameter int WIDTH = 2,
  parameter int PACK  = 4
);
  import fifo_sym_packer_pkg::*;

  localparam int CW = cw_f(PACK);

  logic [WIDTH-1:0]      din;
  logic                  empty;
  logic                  pop;
  logic                  flush;
  logic                  ready;
  logic                  valid;
  logic [WIDTH*PACK-1:0] data;
  logic [CW-1:0]         count;

  modport master (
    input  din, empty, flush, ready,
    output pop, valid, data, count
  );

  modport slave (
    output din, empty, flush, ready,
    input  pop, valid, data, count
  );

endinterface

// File: rtl/fifo_sym_packer.sv
// fifo_sym_packer
//   Pops WIDTH-bit symbols from a FIFO and packs PACK of them LSB-first into
//   one word, presented on a valid/ready port together with a symbol count.
//   A flush emits whatever has been collected so far as a short word.
// Ports
//   clk   : clock, all state on posedge
//   reset : synchronous, active-high; discards any partial word
//   io    : fifo_sym_packer_if.master (FIFO pop side + word output side)
// Only io.pop is combinational; valid/data/count come straight from flops.
module fifo_sym_packer
  import fifo_sym_packer_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int PACK  = 4
) (
  input  logic             clk,
  input  logic             reset,
  fifo_sym_packer_if.master io
);

  localparam int CW   = cw_f(PACK);
  localparam int CNTW = $clog2(PACK);
  localparam logic [CNTW-1:0] LAST = CNTW'(PACK - 1);

  state_e                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [WIDTH*PACK-1:0] data_q, data_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  pop;

  // In OUT a pop is only allowed in the accept cycle, so the popped symbol
  // lands in slot 0 of the next word without a bubble.
  assign pop = !reset && !io.empty &&
               ((state_q == FILL) || ((state_q == OUT) && io.ready));

  assign io.pop   = pop;
  assign io.valid = (state_q == OUT);
  assign io.data  = data_q;
  assign io.count = count_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      FILL: begin
        if (pop) begin
          for (int i = 0; i < PACK; i++) begin
            if (cnt_q == CNTW'(i)) data_d[i*WIDTH +: WIDTH] = io.din;
          end
          cnt_d = cnt_q + 1'b1;
        end
        if (pop && (cnt_q == LAST)) begin
          state_d = OUT;
          count_d = CW'(PACK);
          cnt_d   = '0;
        end else if (io.flush && ((cnt_q != '0) || pop)) begin
          // a symbol popped in the flush cycle belongs to the flushed word
          state_d = OUT;
          count_d = CW'(cnt_q) + CW'(pop);
          cnt_d   = '0;
        end
      end
      OUT: begin
        // flush is deliberately not looked at here; it is not queued
        if (io.ready) begin
          state_d = FILL;
          data_d  = '0;
          count_d = '0;
          cnt_d   = '0;
          if (pop) begin
            data_d[WIDTH-1:0] = io.din;
            cnt_d             = CNTW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_sym_packer.sv
// tb_fifo_sym_packer
//   Drives the packer from a queue-based FIFO and compares every cycle with a
//   reference model that collects symbols into a list and forms words from it.
module tb_fifo_sym_packer;
  localparam int WIDTH = 2;
  localparam int PACK  = 4;
  localparam int DW    = WIDTH * PACK;

  logic clk;
  logic reset;

  fifo_sym_packer_if #(.WIDTH(WIDTH), .PACK(PACK)) io ();

  fifo_sym_packer #(.WIDTH(WIDTH), .PACK(PACK)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // stimulus controls
  logic rst_i, flush_i, ready_i;
  logic [WIDTH-1:0] q[$];     // FIFO contents
  // reference model
  logic [WIDTH-1:0] acc[$];   // symbols collected for the current word
  logic             m_valid;
  logic [DW-1:0]    m_word;
  int               m_count;
  logic             exp_pop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack_acc();
    logic [DW-1:0] w;
    w = '0;
    foreach (acc[i]) w[i*WIDTH +: WIDTH] = acc[i];
    return w;
  endfunction

  // one clock: drive at negedge, compare, then advance the model at posedge
  task automatic step();
    logic [WIDTH-1:0] sym;
    @(negedge clk);
    io.din   = (q.size() > 0) ? q[0] : WIDTH'($urandom);
    io.empty = (q.size() == 0);
    io.flush = flush_i;
    io.ready = ready_i;
    reset    = rst_i;
    exp_pop  = !rst_i && (q.size() > 0) && (!m_valid || ready_i);
    #1;
    chk("pop",   32'(io.pop),   32'(exp_pop));
    chk("valid", 32'(io.valid), 32'(m_valid));
    chk("data",  32'(io.data),  32'(m_valid ? m_word : pack_acc()));
    if (m_valid) chk("count", 32'(io.count), 32'(m_count));
    @(posedge clk);
    sym = '0;
    if (exp_pop) sym = q.pop_front();
    if (rst_i) begin
      m_valid = 1'b0;
      acc.delete();
    end else if (!m_valid) begin
      if (exp_pop) acc.push_back(sym);
      if ((acc.size() == PACK) || (flush_i && (acc.size() > 0))) begin
        m_valid = 1'b1;
        m_word  = pack_acc();
        m_count = acc.size();
        acc.delete();
      end
    end else if (ready_i) begin
      m_valid = 1'b0;
      if (exp_pop) acc.push_back(sym);
    end
    #1;
  endtask

  initial begin
    int lat;
    int vk[$];
    reset = 1'b1; io.din = '0; io.empty = 1'b1; io.flush = 1'b0; io.ready = 1'b0;
    rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
    m_valid = 1'b0; m_word = '0; m_count = 0;
    repeat (2) step();
    rst_i = 1'b0;
    chk("rst_valid", 32'(io.valid), 0);
    chk("rst_data",  32'(io.data),  0);
    chk("rst_count", 32'(io.count), 0);

    // 1: 1,2,3,0 -> 8'h39 one cycle after the 4th pop
    ready_i = 1'b1;
    q.push_back(2'd1); q.push_back(2'd2); q.push_back(2'd3); q.push_back(2'd0);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (io.valid) begin lat = k; break; end
    end
    chk("t1_lat",   32'(lat), 4);
    chk("t1_data",  32'(io.data), 32'h39);
    chk("t1_count", 32'(io.count), 4);
    step();

    // 2: 8 symbols back to back -> two words 4 cycles apart
    for (int i = 0; i < 8; i++) q.push_back(WIDTH'($urandom));
    for (int k = 1; k <= 12; k++) begin
      step();
      if (io.valid) vk.push_back(k);
    end
    chk("t2_words", 32'(vk.size()), 2);
    if (vk.size() == 2) chk("t2_gap", 32'(vk[1] - vk[0]), 4);

    // 3: word held with ready low while the FIFO has data
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back(WIDTH'(i));
    for (int i = 0; i < 4; i++) q.push_back(WIDTH'(3 - i));
    repeat (4) step();
    chk("t3_valid", 32'(io.valid), 1);
    repeat (5) begin
      step();
      chk("t3_hold", 32'(io.data), 32'hE4);
    end
    ready_i = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (io.valid) begin lat = k; break; end
    end
    chk("t3_word2", 32'(io.data), 32'h1B);
    step();

    // 4: 3,1 then flush with FIFO empty -> 8'h07, count 2
    ready_i = 1'b0;
    q.push_back(2'd3); q.push_back(2'd1);
    repeat (3) step();
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("t4_valid", 32'(io.valid), 1);
    chk("t4_data",  32'(io.data),  32'h07);
    chk("t4_count", 32'(io.count), 2);
    ready_i = 1'b1; step();
    q.push_back(2'd2); step();
    chk("t4_slot0", 32'(io.data), 32'h02);
    // drain the lone symbol with a flush so cnt is back at 0
    flush_i = 1'b1; step(); flush_i = 1'b0; step();

    // 5: flush with nothing collected is ignored; flush with a pop counts it
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("t5_ignored", 32'(io.valid), 0);
    q.push_back(2'd2); q.push_back(2'd3);
    step();
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("t5_count", 32'(io.count), 2);
    chk("t5_data",  32'(io.data),  32'h0E);
    step();

    // 6: reset mid-word discards the partial word
    q.push_back(2'd1); q.push_back(2'd1);
    repeat (2) step();
    q.push_back(2'd3); q.push_back(2'd3);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    chk("t6_valid", 32'(io.valid), 0);
    chk("t6_data",  32'(io.data),  0);
    ready_i = 1'b0;
    q.push_back(2'd2); q.push_back(2'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (io.valid) break;
    end
    chk("t6_word", 32'(io.data), 32'h6F);
    ready_i = 1'b1; step();

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      ready_i = ($urandom_range(3) != 0);
      flush_i = ($urandom_range(7) == 0);
      rst_i   = ($urandom_range(199) == 0);
      if ((q.size() < 16) && ($urandom_range(9) < 6)) q.push_back(WIDTH'($urandom));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
